// File: rtl/spi_reg_access_ctrl_if.sv
// Byte-stream (SPI slave side) and register-file signals of spi_reg_access_ctrl.
// master: the controller; slave: the SPI slave / register file environment.
interface spi_reg_access_ctrl_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic [7:0]        tx_data;
    logic              tx_ready;
    logic [ADDR_W-1:0] reg_addr;
    logic [DATA_W-1:0] reg_wdata;
    logic              reg_we;
    logic [DATA_W-1:0] reg_rdata;

    modport master (
        input  rx_data, rx_valid, reg_rdata,
        output tx_data, tx_ready, reg_addr, reg_wdata, reg_we
    );

    modport slave (
        output rx_data, rx_valid, reg_rdata,
        input  tx_data, tx_ready, reg_addr, reg_wdata, reg_we
    );
endinterface

// File: rtl/spi_reg_access_ctrl.sv
// SPI byte-stream to register-file access controller with burst, wrap and access protection.
// Optional idle timeout enabled by defining SPI_RAC_TIMEOUT_EN (adds parameter TIMEOUT_CYC).
module spi_reg_access_ctrl #(
    parameter int NREG_WR = 41,
    parameter int NREG_RD = 6,
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 8
`ifdef SPI_RAC_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 4096
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    spi_reg_access_ctrl_if.master bus,
    output logic                  busy,
    output logic                  err,
    input  logic                  err_clr
);

    localparam int unsigned BPW       = DATA_W / 8;
    localparam int unsigned NWR       = NREG_WR;
    localparam int unsigned NREG      = NREG_WR + NREG_RD;
    localparam logic [1:0]  LAST_BYTE = 2'(BPW - 1);

    typedef enum logic [2:0] {IDLE, LEN, WDATA, RFETCH, RDATA} state_t;

    state_t            state_q, state_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [8:0]        rem_q, rem_d;
    logic [1:0]        bcnt_q, bcnt_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [7:0]        txd_q, txd_d;
    logic              txr_q, txr_d;
    logic              we_q, we_d;
    logic              wpend_q, wpend_d;
    logic              err_q, err_d;
    logic              err_set;
    logic [DATA_W-1:0] shifted;
    logic [ADDR_W-1:0] addr_inc;
    logic [ADDR_W-1:0] wr_addr;
    logic              writable;
    logic              readable;
    logic              last_word_pending;

`ifdef SPI_RAC_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

    always_comb begin
        state_d  = state_q;
        write_d  = write_q;
        addr_d   = addr_q;
        rem_d    = rem_q;
        bcnt_d   = bcnt_q;
        wdata_d  = wdata_q;
        shreg_d  = shreg_q;
        txd_d    = txd_q;
        txr_d    = 1'b0;
        we_d     = 1'b0;
        wpend_d  = 1'b0;
        err_set  = 1'b0;

        shifted  = shreg_q << 8;
        addr_inc = (32'(addr_q) == NREG - 1) ? '0 : addr_q + ADDR_W'(1);
        // A word completing in the strobe cycle of its predecessor lands on the next address
        wr_addr  = wpend_q ? addr_inc : addr_q;
        writable = (32'(wr_addr) < NWR);
        readable = (32'(addr_q) < NREG);
        last_word_pending = wpend_q && (rem_q == 9'd1);

        unique case (state_q)
            IDLE: begin
                if (bus.rx_valid) begin
                    write_d = bus.rx_data[7];
                    addr_d  = bus.rx_data[ADDR_W-1:0];
                    rem_d   = 9'd1;
                    bcnt_d  = '0;
                    if (bus.rx_data[6])      state_d = LEN;
                    else if (bus.rx_data[7]) state_d = WDATA;
                    else                     state_d = RFETCH;
                end
            end
            LEN: begin
                if (bus.rx_valid) begin
                    rem_d   = {1'b0, bus.rx_data} + 9'd1;
                    state_d = write_q ? WDATA : RFETCH;
                end
            end
            WDATA: begin
                if (wpend_q) begin
                    addr_d = addr_inc;
                    rem_d  = rem_q - 9'd1;
                    if (rem_q == 9'd1) state_d = IDLE;
                end
                if (bus.rx_valid && !last_word_pending) begin
                    wdata_d = (wdata_q << 8) | DATA_W'(bus.rx_data);
                    if (bcnt_q == LAST_BYTE) begin
                        bcnt_d  = '0;
                        wpend_d = 1'b1;
                        we_d    = writable;
                        err_set = !writable;
                    end else begin
                        bcnt_d = bcnt_q + 2'd1;
                    end
                end
            end
            RFETCH: begin
                if (readable) begin
                    shreg_d = bus.reg_rdata;
                    txd_d   = bus.reg_rdata[DATA_W-1 -: 8];
                end else begin
                    shreg_d = '0;
                    txd_d   = '0;
                    err_set = 1'b1;
                end
                txr_d   = 1'b1;
                bcnt_d  = '0;
                state_d = RDATA;
            end
            RDATA: begin
                if (bus.rx_valid) begin
                    if (bcnt_q != LAST_BYTE) begin
                        bcnt_d  = bcnt_q + 2'd1;
                        shreg_d = shifted;
                        txd_d   = shifted[DATA_W-1 -: 8];
                        txr_d   = 1'b1;
                    end else if (rem_q != 9'd1) begin
                        rem_d   = rem_q - 9'd1;
                        addr_d  = addr_inc;
                        state_d = RFETCH;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef SPI_RAC_TIMEOUT_EN
        if (state_q == IDLE || bus.rx_valid) tmo_d = '0;
        else                                 tmo_d = tmo_q + TMO_W'(1);
        // Abandon the transaction; a partially assembled or pending word is dropped
        if (state_q != IDLE && tmo_q == TMO_W'(TIMEOUT_CYC)) begin
            state_d = IDLE;
            we_d    = 1'b0;
            wpend_d = 1'b0;
            txr_d   = 1'b0;
            wdata_d = '0;
            bcnt_d  = '0;
            tmo_d   = '0;
            err_set = 1'b1;
        end
`endif

        if (err_set)      err_d = 1'b1;
        else if (err_clr) err_d = 1'b0;
        else              err_d = err_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            addr_q  <= '0;
            rem_q   <= '0;
            bcnt_q  <= '0;
            wdata_q <= '0;
            shreg_q <= '0;
            txd_q   <= '0;
            txr_q   <= 1'b0;
            we_q    <= 1'b0;
            wpend_q <= 1'b0;
            err_q   <= 1'b0;
`ifdef SPI_RAC_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            bcnt_q  <= bcnt_d;
            wdata_q <= wdata_d;
            shreg_q <= shreg_d;
            txd_q   <= txd_d;
            txr_q   <= txr_d;
            we_q    <= we_d;
            wpend_q <= wpend_d;
            err_q   <= err_d;
`ifdef SPI_RAC_TIMEOUT_EN
            tmo_q   <= tmo_d;
`endif
        end
    end

    assign bus.tx_data   = txd_q;
    assign bus.tx_ready  = txr_q;
    assign bus.reg_addr  = addr_q;
    assign bus.reg_wdata = wdata_q;
    assign bus.reg_we    = we_q;
    assign busy          = (state_q != IDLE);
    assign err           = err_q;

endmodule
